// File: rtl/onehot_encoder_ser.sv
// Serialising one-hot/multi-hot line encoder: captures a line vector and emits the
// index of every set bit, lowest first, one code per valid/ready handshake.
module onehot_encoder_ser #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] D,
    input  logic         d_valid,
    output logic         d_ready,
    output logic [W-1:0] I,
    output logic         i_valid,
    input  logic         i_ready,
    output logic         i_last,
    output logic         multi,
    output logic         zero_err
);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic         multi_q, multi_d;
    logic         zero_err_q, zero_err_d;
    logic [N-1:0] rem;

    function automatic logic [W-1:0] low_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        code_d     = code_q;
        valid_d    = valid_q;
        last_d     = last_q;
        multi_d    = multi_q;
        zero_err_d = 1'b0;
        rem        = pend_q & ~(N'(1) << code_q);

        unique case (state_q)
            StIdle: begin
                if (d_valid) begin
                    if (D != '0) begin
                        state_d = StEmit;
                        pend_d  = D;
                        code_d  = low_idx(D);
                        valid_d = 1'b1;
                        last_d  = single_bit(D);
                        multi_d = !single_bit(D);
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (i_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                        pend_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        multi_d = 1'b0;
                    end else begin
                        pend_d = rem;
                        code_d = low_idx(rem);
                        last_d = single_bit(rem);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pend_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            multi_q    <= 1'b0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            multi_q    <= multi_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign d_ready  = (state_q == StIdle);
    assign I        = code_q;
    assign i_valid  = valid_q;
    assign i_last   = last_q;
    assign multi    = multi_q;
    assign zero_err = zero_err_q;

endmodule

// File: tb/tb_onehot_encoder_ser.sv
// Bench for onehot_encoder_ser: directed cycle table, reset-in-emit sequence and
// randomised traffic against a queue-based model of the emitted codes.
module tb_onehot_encoder_ser;

    logic       clk;
    logic       rst_n;
    logic [3:0] D;
    logic       d_valid;
    logic       d_ready;
    logic [1:0] I;
    logic       i_valid;
    logic       i_ready;
    logic       i_last;
    logic       multi;
    logic       zero_err;

    int total = 0;
    int bad   = 0;

    onehot_encoder_ser #(.N(4), .W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .D        (D),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .I        (I),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_last   (i_last),
        .multi    (multi),
        .zero_err (zero_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       dv;
        logic       ir;
        logic [1:0] e_i;
        logic       e_iv;
        logic       e_last;
        logic       e_multi;
        logic       e_zerr;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] d, input logic dv, input logic ir, input logic [1:0] e_i,
                       input logic e_iv, input logic e_last, input logic e_multi,
                       input logic e_zerr, input logic e_rdy);
        vec_t v;
        v.d = d; v.dv = dv; v.ir = ir; v.e_i = e_i; v.e_iv = e_iv;
        v.e_last = e_last; v.e_multi = e_multi; v.e_zerr = e_zerr; v.e_rdy = e_rdy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_i, input logic e_iv,
                           input logic e_last, input logic e_multi, input logic e_zerr,
                           input logic e_rdy);
        chk({tag, ".i_valid"}, 32'(i_valid), 32'(e_iv));
        if (e_iv) chk({tag, ".I"}, 32'(I), 32'(e_i));
        chk({tag, ".i_last"}, 32'(i_last), 32'(e_last));
        chk({tag, ".multi"}, 32'(multi), 32'(e_multi));
        chk({tag, ".zero_err"}, 32'(zero_err), 32'(e_zerr));
        chk({tag, ".d_ready"}, 32'(d_ready), 32'(e_rdy));
    endtask

    task automatic cycle(input logic [3:0] d, input logic dv, input logic ir);
        D = d; d_valid = dv; i_ready = ir;
        @(posedge clk);
        #1;
    endtask

    int         q[$];
    logic       m_multi;
    logic [3:0] rd;
    logic       rdv, rir;
    logic [1:0] x_i;
    logic       x_iv, x_last, x_multi, x_zerr, x_rdy;

    initial begin
        rst_n = 1'b0; D = '0; d_valid = 1'b0; i_ready = 1'b0;
        #3;
        chk("reset.I", 32'(I), 32'd0);
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #9 rst_n = 1'b1;
        chk_all("release", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        //   d        dv ir  I     iv last mul zerr rdy
        add(4'b0001, 1, 1, 2'd0, 1, 1, 0, 0, 0);
        add(4'b0000, 0, 1, 2'd0, 0, 0, 0, 0, 1);
        add(4'b1111, 1, 1, 2'd0, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd1, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd2, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd3, 1, 1, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd0, 0, 0, 0, 0, 1);
        add(4'b1010, 1, 0, 2'd1, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 0, 2'd1, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 0, 2'd1, 1, 0, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd3, 1, 1, 1, 0, 0);
        add(4'b0000, 0, 1, 2'd0, 0, 0, 0, 0, 1);
        add(4'b0000, 1, 0, 2'd0, 0, 0, 0, 1, 1);
        add(4'b0000, 0, 0, 2'd0, 0, 0, 0, 0, 1);
        add(4'b0110, 1, 0, 2'd1, 1, 0, 1, 0, 0);
        add(4'b1000, 1, 0, 2'd1, 1, 0, 1, 0, 0);
        add(4'b1000, 1, 1, 2'd2, 1, 1, 1, 0, 0);
        add(4'b1000, 0, 1, 2'd0, 0, 0, 0, 0, 1);

        foreach (tbl[k]) begin
            cycle(tbl[k].d, tbl[k].dv, tbl[k].ir);
            chk_all($sformatf("tbl%0d", k), tbl[k].e_i, tbl[k].e_iv, tbl[k].e_last,
                    tbl[k].e_multi, tbl[k].e_zerr, tbl[k].e_rdy);
        end

        // Reset dropped while the second code of 4'b1100 is pending.
        cycle(4'b1100, 1'b1, 1'b1);
        chk_all("rst.cap", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        chk_all("rst.second", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b1;
        chk_all("rst.release", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        chk_all("rst.idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(4'b0100, 1'b1, 1'b1);
        chk_all("rst.new", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        chk_all("rst.done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic; the model keeps the codes still owed for the captured vector.
        m_multi = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rd  = 4'($urandom_range(0, 15));
            rdv = ($urandom_range(0, 1) == 1);
            rir = ($urandom_range(0, 3) != 0);
            x_i = 2'd0; x_iv = 1'b0; x_last = 1'b0; x_multi = 1'b0; x_zerr = 1'b0; x_rdy = 1'b1;
            if (q.size() == 0) begin
                if (rdv && rd != 4'b0000) begin
                    for (int b = 0; b < 4; b++) if (rd[b]) q.push_back(b);
                    m_multi = (q.size() > 1);
                end else begin
                    x_zerr = rdv;
                end
            end else if (rir) begin
                void'(q.pop_front());
            end
            if (q.size() != 0) begin
                x_iv = 1'b1; x_i = 2'(q[0]); x_last = (q.size() == 1);
                x_multi = m_multi; x_rdy = 1'b0;
            end
            cycle(rd, rdv, rir);
            chk_all($sformatf("rnd%0d", n), x_i, x_iv, x_last, x_multi, x_zerr, x_rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_ser.md
Name: onehot_encoder_ser

Overview:
- Sequential counterpart of the team's 2-to-4 decoder: accepts a 4-bit line vector D and returns the 2-bit code(s) I that would drive the decoder.
- A one-hot D yields one code. A multi-hot D is buffered and serialised into one code per handshake, lowest index first.
- Sits between request/status lines and any consumer of binary line indices. Valid/ready handshake on both sides.

Parameters:
- N, 4, number of input lines (N ≥ 2, power of two).
- W, 2, code width; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- D  input  N  line vector to encode.
- d_valid  input  1  D is valid this cycle.
- d_ready  output  1  block can capture D (high only in IDLE).
- I  output  W  encoded line index.
- i_valid  output  1  I is valid.
- i_ready  input  1  consumer accepts I.
- i_last  output  1  I is the final code of the current captured vector.
- multi  output  1  captured vector had more than one bit set; held for the whole emission.
- zero_err  output  1  one-cycle pulse: an all-zero D was presented with d_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pend=0, I=0, i_valid=0, i_last=0, multi=0, zero_err=0.
  - d_ready=1 as soon as reset releases.
- Registers and decode:
  - I, i_valid, i_last, multi and zero_err are registered.
  - d_ready is decoded directly from state (high iff IDLE).
- IDLE:
  - d_valid=1 and D≠0: capture pend←D; go to EMIT.
    - Next cycle: i_valid=1, I=index of lowest set bit of D.
    - i_last=1 iff popcount(D)=1; multi=1 iff popcount(D)>1.
    - Latency from capture edge to i_valid is 1 cycle.
  - d_valid=1 and D=0: zero_err=1 for exactly the next cycle; stay IDLE; no code emitted.
  - d_valid=0: hold; zero_err=0.
- EMIT:
  - d_ready=0; d_valid and D are ignored (no capture, no zero_err).
  - i_valid=1, i_ready=0: I, i_last and multi held stable (no change while stalled).
  - i_valid=1, i_ready=1, not i_last: clear the emitted bit in pend.
    - Next cycle: I=next-lowest set bit; i_last recomputed from the remaining pend.
    - One code per cycle under continuous i_ready.
  - i_valid=1, i_ready=1, i_last=1: pend←0; go to IDLE.
    - Next cycle: i_valid=0, i_last=0, multi=0, d_ready=1.
    - I keeps its last value; don't-care while i_valid=0.
    - New input is capturable from that cycle, giving one idle cycle between vectors.
- Ordering: codes always strictly ascending within one vector; each set bit emitted exactly once.
- Codes are exact W-bit indices; no wrap or overflow is possible.
- Reset asserted mid-EMIT:
  - Immediate return to reset values; pend discarded.
  - No partial code is visible after release.
- zero_err never coincides with i_valid=1.

Test Plan:
- Reset, then D=4'b0001, d_valid 1 cycle, i_ready=1 → next cycle I=2'b00, i_valid=1, i_last=1, multi=0; the cycle after: i_valid=0, d_ready=1.
- D=4'b1111, i_ready held 1 → I=00,01,10,11 on 4 consecutive cycles; i_last only on 11; multi=1 throughout; d_ready=0 for those 4 cycles.
- D=4'b1010, i_ready=0 for 3 cycles then 1 → I=01 held 3 cycles with i_last=0, then I=11 with i_last=1, then IDLE.
- D=4'b0000 with d_valid → zero_err=1 for exactly one cycle, i_valid stays 0, d_ready stays 1.
- During EMIT of 4'b0110, present D=4'b1000 with d_valid → ignored; output sequence is exactly 01, 10; no code 11 appears.
- D=4'b1100, drop rst_n after the first code (10) handshakes → i_valid=0 asynchronously; after release d_ready=1, and D=4'b0100 then yields the single code 10 with i_last=1.
